// File: rtl/csi2_tx_packetizer.sv
// csi2_tx_packetizer: 2-lane CSI-2 HS packet transmitter (LP entry, sync, header+ECC, payload, CRC, trail).
// Optional macro CSI_TX_CRC_EN enables the payload CRC-16; when undefined the CRC slot carries 0x0000.
module csi2_tx_packetizer #(
    parameter int T_LPX      = 2,
    parameter int T_HS_ZERO  = 6,
    parameter int T_HS_TRAIL = 4,
    parameter int T_LP_GAP   = 8
) (
    input  logic        mipi_clk_8,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_dt,
    input  logic [1:0]  cmd_vc,
    input  logic [15:0] cmd_wc,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  lane0_byte,
    output logic [7:0]  lane1_byte,
    output logic        hs_en,
    output logic [1:0]  lane0_lp,
    output logic [1:0]  lane1_lp,
    output logic        busy,
    output logic        cmd_err,
    output logic        underrun
);

    typedef enum logic [3:0] {
        S_IDLE, S_LP01, S_LP00, S_HS_ZERO, S_SYNC, S_HDR0,
        S_HDR1, S_PAYLOAD, S_CRC, S_TRAIL, S_GAP
    } state_t;

    localparam logic [15:0] LPX_M1   = 16'(T_LPX - 1);
    localparam logic [15:0] HSZ_M1   = 16'(T_HS_ZERO - 1);
    localparam logic [15:0] TRAIL_M1 = 16'(T_HS_TRAIL - 1);
    localparam logic [15:0] GAP_M1   = 16'(T_LP_GAP - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        armed_q, armed_d;
    logic        cmd_err_q, cmd_err_d;
    logic        underrun_q, underrun_d;
    logic [5:0]  dt_q, dt_d;
    logic [1:0]  vc_q, vc_d;
    logic [15:0] wc_q, wc_d;
    logic        long_q, long_d;
    logic [7:0]  lane0_q, lane0_d;
    logic [7:0]  lane1_q, lane1_d;
    logic        hs_en_q, hs_en_d;
    logic [1:0]  lp_q, lp_d;

    logic        cmd_long, cmd_bad, accept, take;
    logic [7:0]  pay0, pay1;
    logic [15:0] crc_val;

    function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    assign cmd_long  = (cmd_dt[5:4] != 2'b00);
    assign cmd_bad   = cmd_long & cmd_wc[0];
    assign cmd_ready = (state_q == S_IDLE) & armed_q;
    assign accept    = cmd_valid & cmd_ready;
    assign take      = accept & ~cmd_bad;
    assign pix_ready = (state_q == S_PAYLOAD);
    assign busy      = (state_q != S_IDLE);
    // A missing word still occupies its HS slot, sent as zeros.
    assign pay0      = pix_valid ? pix_data[7:0]  : 8'h00;
    assign pay1      = pix_valid ? pix_data[15:8] : 8'h00;

`ifdef CSI_TX_CRC_EN
    logic [15:0] crc_q, crc_d;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = {1'b0, r[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
        end
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (take) begin
            crc_d = 16'hFFFF;
        end else if (pix_ready) begin
            crc_d = crc16_byte(crc16_byte(crc_q, pay0), pay1);
        end
    end

    always_ff @(posedge mipi_clk_8) begin
        crc_q <= crc_d;
    end

    assign crc_val = crc_q;
`else
    assign crc_val = 16'h0000;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q != 16'd0) ? cnt_q - 16'd1 : 16'd0;
        armed_d    = (state_q == S_IDLE) & ~take;
        cmd_err_d  = accept & cmd_bad;
        underrun_d = underrun_q;
        dt_d       = dt_q;
        vc_d       = vc_q;
        wc_d       = wc_q;
        long_d     = long_q;
        if (take) begin
            dt_d       = cmd_dt;
            vc_d       = cmd_vc;
            wc_d       = cmd_wc;
            long_d     = cmd_long;
            underrun_d = 1'b0;
        end
        if (pix_ready & ~pix_valid) begin
            underrun_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    state_d = S_LP01;
                    cnt_d   = LPX_M1;
                end
            end
            S_LP01: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_LP00;
                    cnt_d   = LPX_M1;
                end
            end
            S_LP00: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_HS_ZERO;
                    cnt_d   = HSZ_M1;
                end
            end
            S_HS_ZERO: begin
                if (cnt_q == 16'd0) state_d = S_SYNC;
            end
            S_SYNC: state_d = S_HDR0;
            S_HDR0: state_d = S_HDR1;
            S_HDR1: begin
                if (!long_q) begin
                    state_d = S_TRAIL;
                    cnt_d   = TRAIL_M1;
                end else if (wc_q == 16'd0) begin
                    state_d = S_CRC;
                end else begin
                    state_d = S_PAYLOAD;
                    cnt_d   = {1'b0, wc_q[15:1]} - 16'd1;
                end
            end
            S_PAYLOAD: begin
                if (cnt_q == 16'd0) state_d = S_CRC;
            end
            S_CRC: begin
                state_d = S_TRAIL;
                cnt_d   = TRAIL_M1;
            end
            S_TRAIL: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_M1;
                end
            end
            S_GAP: begin
                if (cnt_q == 16'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line outputs are registered: what a state emits reaches the pins one cycle later.
    always_comb begin
        lane0_d = 8'h00;
        lane1_d = 8'h00;
        hs_en_d = 1'b0;
        lp_d    = 2'b11;
        case (state_q)
            S_LP01: lp_d = 2'b01;
            S_LP00: lp_d = 2'b00;
            S_HS_ZERO: begin
                hs_en_d = 1'b1;
                lp_d    = 2'b00;
            end
            S_SYNC: begin
                hs_en_d = 1'b1;
                lp_d    = 2'b00;
                lane0_d = 8'hB8;
                lane1_d = 8'hB8;
            end
            S_HDR0: begin
                hs_en_d = 1'b1;
                lp_d    = 2'b00;
                lane0_d = {vc_q, dt_q};
                lane1_d = wc_q[7:0];
            end
            S_HDR1: begin
                hs_en_d = 1'b1;
                lp_d    = 2'b00;
                lane0_d = wc_q[15:8];
                lane1_d = {2'b00, hdr_ecc({wc_q, vc_q, dt_q})};
            end
            S_PAYLOAD: begin
                hs_en_d = 1'b1;
                lp_d    = 2'b00;
                lane0_d = pay0;
                lane1_d = pay1;
            end
            S_CRC: begin
                hs_en_d = 1'b1;
                lp_d    = 2'b00;
                lane0_d = crc_val[7:0];
                lane1_d = crc_val[15:8];
            end
            S_TRAIL: begin
                // First trail cycle inverts the last data bit; later cycles hold it.
                hs_en_d = 1'b1;
                lp_d    = 2'b00;
                lane0_d = (cnt_q == TRAIL_M1) ? {8{~lane0_q[7]}} : lane0_q;
                lane1_d = (cnt_q == TRAIL_M1) ? {8{~lane1_q[7]}} : lane1_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge mipi_clk_8 or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            armed_q    <= 1'b0;
            cmd_err_q  <= 1'b0;
            underrun_q <= 1'b0;
            lane0_q    <= 8'h00;
            lane1_q    <= 8'h00;
            hs_en_q    <= 1'b0;
            lp_q       <= 2'b11;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            cmd_err_q  <= cmd_err_d;
            underrun_q <= underrun_d;
            lane0_q    <= lane0_d;
            lane1_q    <= lane1_d;
            hs_en_q    <= hs_en_d;
            lp_q       <= lp_d;
        end
    end

    always_ff @(posedge mipi_clk_8) begin
        dt_q   <= dt_d;
        vc_q   <= vc_d;
        wc_q   <= wc_d;
        long_q <= long_d;
    end

    assign lane0_byte = lane0_q;
    assign lane1_byte = lane1_q;
    assign hs_en      = hs_en_q;
    assign lane0_lp   = lp_q;
    assign lane1_lp   = lp_q;
    assign cmd_err    = cmd_err_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_csi2_tx_packetizer.sv
// Directed bench for csi2_tx_packetizer: per-cycle frame vectors with hand-derived headers and a CRC-16 reference.
module tb_csi2_tx_packetizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_dt = 6'h00;
    logic [1:0]  cmd_vc = 2'b00;
    logic [15:0] cmd_wc = 16'h0000;
    logic [15:0] pix_data = 16'h0000;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  lane0_byte, lane1_byte;
    logic        hs_en;
    logic [1:0]  lane0_lp, lane1_lp;
    logic        busy, cmd_err, underrun;

    int tests = 0;
    int fails = 0;

    // {hs, pix_ready, busy, cmd_ready, underrun, lane0, lane1, lp0, lp1}; lanes masked when LP, lp masked when HS
    logic [24:0] cap_vec [0:511];
    logic [24:0] exp_vec [0:511];
    logic [7:0]  cap_l0 [0:511];
    logic [7:0]  cap_l1 [0:511];
    int          exp_len;

    always #5 clk = ~clk;

    csi2_tx_packetizer dut (
        .mipi_clk_8 (clk),
        .reset      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dt     (cmd_dt),
        .cmd_vc     (cmd_vc),
        .cmd_wc     (cmd_wc),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .lane0_byte (lane0_byte),
        .lane1_byte (lane1_byte),
        .hs_en      (hs_en),
        .lane0_lp   (lane0_lp),
        .lane1_lp   (lane1_lp),
        .busy       (busy),
        .cmd_err    (cmd_err),
        .underrun   (underrun)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) begin
            if (r[0]) r = (r >> 1) ^ 16'h8408;
            else      r = r >> 1;
        end
        return r;
    endfunction

    task automatic send_cmd(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc);
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL cmd_ready_timeout got 0 exp 1");
        end else begin
            cmd_dt    = dt;
            cmd_vc    = vc;
            cmd_wc    = wc;
            cmd_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic record(input int n, input int bad_word);
        int widx;
        widx = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_l0[i]  = lane0_byte;
            cap_l1[i]  = lane1_byte;
            cap_vec[i] = {hs_en, pix_ready, busy, cmd_ready, underrun,
                          hs_en ? lane0_byte : 8'h00, hs_en ? lane1_byte : 8'h00,
                          hs_en ? 2'b00 : lane0_lp, hs_en ? 2'b00 : lane1_lp};
            if (pix_ready) begin
                pix_valid = (widx != bad_word);
                pix_data  = (widx == bad_word) ? 16'hDEAD : 16'h0100 + 16'(widx);
                widx++;
            end else begin
                pix_valid = 1'b0;
                pix_data  = 16'h0000;
            end
        end
    endtask

    task automatic build_expected(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc,
                                  input logic [7:0] ecc, input bit is_long, input int bad_word);
        int          n;
        logic [15:0] crc, w;
        logic [7:0]  l0, l1, tl0, tl1;
        logic [1:0]  lp;
        logic        hs;
        n       = is_long ? int'(wc[15:1]) : 0;
        exp_len = 13 + n + (is_long ? 1 : 0) + 12;
        crc     = 16'hFFFF;
        tl0     = 8'h00;
        tl1     = 8'h00;
        for (int i = 0; i < exp_len + 2; i++) begin
            hs = 1'b0; l0 = 8'h00; l1 = 8'h00; lp = 2'b11;
            if (i < 2) lp = 2'b01;
            else if (i < 4) lp = 2'b00;
            else if (i < exp_len - 8) hs = 1'b1;
            if (i == 10) begin
                l0 = 8'hB8; l1 = 8'hB8;
            end else if (i == 11) begin
                l0 = {vc, dt}; l1 = wc[7:0];
            end else if (i == 12) begin
                l0 = wc[15:8]; l1 = ecc;
            end else if (i >= 13 && i < 13 + n) begin
                w  = (i - 13 == bad_word) ? 16'h0000 : 16'h0100 + 16'(i - 13);
                l0 = w[7:0]; l1 = w[15:8];
                crc = crc_upd(crc_upd(crc, l0), l1);
            end else if (is_long && i == 13 + n) begin
`ifdef CSI_TX_CRC_EN
                l0 = crc[7:0]; l1 = crc[15:8];
`endif
            end else if (hs && i >= exp_len - 12) begin
                l0 = {8{~tl0[7]}}; l1 = {8{~tl1[7]}};
            end
            if (hs && i < exp_len - 12) begin
                tl0 = l0; tl1 = l1;
            end
            exp_vec[i] = {hs, (i >= 12 && i < 12 + n), (i < exp_len - 1), (i >= exp_len),
                          (bad_word >= 0 && i >= 13 + bad_word),
                          hs ? l0 : 8'h00, hs ? l1 : 8'h00, hs ? 2'b00 : lp, hs ? 2'b00 : lp};
        end
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({cmd_ready, pix_ready, hs_en, lane0_byte, lane1_byte, lane0_lp, lane1_lp, busy, cmd_err, underrun}
            !== {1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values got %b exp all idle", {cmd_ready, pix_ready, hs_en, lane0_lp, lane1_lp, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_first_idle_cycle got %b exp 0", cmd_ready);
        end
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_second_idle_cycle got %b exp 1", cmd_ready);
        end
    endtask

    task automatic test_short();
        build_expected(6'h00, 2'd0, 16'h0001, 8'h1A, 1'b0, -1);
        send_cmd(6'h00, 2'd0, 16'h0001);
        record(exp_len + 2, -1);
        for (int i = 0; i < exp_len + 2; i++) begin
            tests++;
            if (cap_vec[i] !== exp_vec[i]) begin
                fails++;
                $display("FAIL short_frame cyc %0d got %h exp %h", i, cap_vec[i], exp_vec[i]);
            end
        end
        tests++;
        if ({cap_l0[11], cap_l0[12], cap_l1[11], cap_l1[12], cap_l0[13], cap_l1[16]}
            !== {8'h00, 8'h00, 8'h01, 8'h1A, 8'hFF, 8'hFF}) begin
            fails++;
            $display("FAIL short_header got %h %h %h %h exp 00 00 01 1a",
                     cap_l0[11], cap_l0[12], cap_l1[11], cap_l1[12]);
        end
    endtask

    task automatic test_long();
        int prc;
        build_expected(6'h2A, 2'd0, 16'h0280, 8'h0E, 1'b1, -1);
        send_cmd(6'h2A, 2'd0, 16'h0280);
        record(exp_len + 2, -1);
        prc = 0;
        for (int i = 0; i < exp_len + 2; i++) begin
            prc += int'(cap_vec[i][23]);
            tests++;
            if (cap_vec[i] !== exp_vec[i]) begin
                fails++;
                $display("FAIL long_frame cyc %0d got %h exp %h", i, cap_vec[i], exp_vec[i]);
            end
        end
        tests++;
        if ({cap_l0[11], cap_l0[12], cap_l1[11], cap_l1[12]} !== {8'h2A, 8'h02, 8'h80, 8'h0E}) begin
            fails++;
            $display("FAIL long_header got %h %h %h %h exp 2a 02 80 0e",
                     cap_l0[11], cap_l0[12], cap_l1[11], cap_l1[12]);
        end
        tests++;
        if (prc !== 320) begin
            fails++;
            $display("FAIL long_pix_ready_count got %0d exp 320", prc);
        end
    endtask

    task automatic test_long_empty();
        logic [15:0] exp_crc;
`ifdef CSI_TX_CRC_EN
        exp_crc = 16'hFFFF;
`else
        exp_crc = 16'h0000;
`endif
        build_expected(6'h2A, 2'd0, 16'h0000, 8'h10, 1'b1, -1);
        send_cmd(6'h2A, 2'd0, 16'h0000);
        record(exp_len + 2, -1);
        for (int i = 0; i < exp_len + 2; i++) begin
            tests++;
            if (cap_vec[i] !== exp_vec[i]) begin
                fails++;
                $display("FAIL empty_frame cyc %0d got %h exp %h", i, cap_vec[i], exp_vec[i]);
            end
        end
        tests++;
        if ({cap_l1[13], cap_l0[13]} !== exp_crc) begin
            fails++;
            $display("FAIL empty_crc got %h%h exp %h", cap_l1[13], cap_l0[13], exp_crc);
        end
    endtask

    task automatic test_bad_cmd();
        int pulses, hs_seen, busy_seen;
        send_cmd(6'h2B, 2'd0, 16'h0003);
        pulses = int'(cmd_err);
        hs_seen = int'(hs_en);
        busy_seen = int'(busy);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pulses += int'(cmd_err);
            hs_seen += int'(hs_en);
            busy_seen += int'(busy);
        end
        tests++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL bad_cmd_err_pulses got %0d exp 1", pulses);
        end
        tests++;
        if ({hs_seen, busy_seen} !== {32'd0, 32'd0}) begin
            fails++;
            $display("FAIL bad_cmd_idle got hs %0d busy %0d exp 0 0", hs_seen, busy_seen);
        end
    endtask

    task automatic test_underrun();
        build_expected(6'h2A, 2'd0, 16'h0004, 8'h33, 1'b1, 1);
        send_cmd(6'h2A, 2'd0, 16'h0004);
        record(exp_len + 2, 1);
        for (int i = 0; i < exp_len + 2; i++) begin
            tests++;
            if (cap_vec[i] !== exp_vec[i]) begin
                fails++;
                $display("FAIL underrun_frame cyc %0d got %h exp %h", i, cap_vec[i], exp_vec[i]);
            end
        end
        @(negedge clk);
        tests++;
        if (underrun !== 1'b1) begin
            fails++;
            $display("FAIL underrun_sticky got %b exp 1", underrun);
        end
        send_cmd(6'h00, 2'd0, 16'h0001);
        tests++;
        if (underrun !== 1'b0) begin
            fails++;
            $display("FAIL underrun_clear got %b exp 0", underrun);
        end
        record(27, -1);
    endtask

    task automatic test_reset_mid();
        int k;
        send_cmd(6'h2A, 2'd0, 16'h0010);
        k = 0;
        while (!pix_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (pix_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reach_payload got %b exp 1", pix_ready);
        end
        pix_valid = 1'b1;
        pix_data  = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({hs_en, lane0_lp, lane1_lp, busy, pix_ready, lane0_byte, lane1_byte}
            !== {1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            fails++;
            $display("FAIL mid_reset got hs %b lp %b%b busy %b exp 0 1111 0", hs_en, lane0_lp, lane1_lp, busy);
        end
        pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        build_expected(6'h01, 2'd0, 16'h0001, 8'h1D, 1'b0, -1);
        send_cmd(6'h01, 2'd0, 16'h0001);
        record(exp_len + 2, -1);
        for (int i = 0; i < exp_len + 2; i++) begin
            tests++;
            if (cap_vec[i] !== exp_vec[i]) begin
                fails++;
                $display("FAIL post_reset_frame cyc %0d got %h exp %h", i, cap_vec[i], exp_vec[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_long_empty();
        test_bad_cmd();
        test_underrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
